vga_timing_pipe: RTL and testbench
==================================

// Module: vga_timing_pipe
// PURPOSE
//  Parametrised VGA raster engine; successor to the fixed 800x600 red-screen generator.
//  Generates HS/VS/DE from programmable porch/sync parameters.
//  Issues pixel requests (x,y) to a framebuffer with fixed 1-cycle read latency.
//  Drives registered, sync-aligned RGB to the DE10-Lite VGA DAC.
// PARAMETERS
//  H_VIS 800 | H_FP 56 | H_SYNC 120 | H_BP 64   horizontal pixels per region
//  V_VIS 600 | V_FP 37 | V_SYNC 6   | V_BP 23   vertical lines per region
//  HS_POL 1, VS_POL 1    sync active level (1 = active-high)
//  COLOR_W 4             bits per colour channel
//  Derived: H_TOT = sum of H_*, V_TOT = sum of V_*; HCW = $clog2(H_TOT), VCW = $clog2(V_TOT).
// PORTS
//  MAX10_CLK1_50  in   1          pixel clock; all logic on rising edge
//  rst_n          in   1          asynchronous active-low reset
//  pix_req        out  1          request a pixel for (pix_x,pix_y) this cycle
//  pix_x          out  HCW        requested column, 0..H_VIS-1
//  pix_y          out  VCW        requested row, 0..V_VIS-1
//  pix_rgb        in   3*COLOR_W  {R,G,B}; valid the cycle after pix_req
//  frame_start    out  1          1-cycle pulse at counter (h,v) = (0,0)
//  line_start     out  1          1-cycle pulse at every h = 0
//  VGA_R/G/B      out  COLOR_W    registered colour outputs
//  VGA_HS, VGA_VS out  1          registered syncs
// BEHAVIOUR
//  Counters: h 0..H_TOT-1; v 0..V_TOT-1. h wraps to 0 after H_TOT-1, and v increments in the same cycle.
//   v wraps to 0 after V_TOT-1 at the h wrap.
//  Region order within a line or frame: visible, front porch, sync, back porch. Counter 0 is the first visible pixel.
//  Stage 0 (counter cycle): pix_req = h<H_VIS && v<V_VIS. pix_x=h, pix_y=v when pix_req, else 0.
//   Also in stage 0: line_start=(h==0), frame_start=(h==0&&v==0). All of these are combinational from the counters.
//  Stage 1: hs_raw/vs_raw/de_raw registered from the stage-0 counters. pix_rgb is valid in this cycle.
//  Stage 2: VGA_* registered. VGA_R/G/B = de_s1 ? pix_rgb : 0.
//   VGA_HS = HS_POL ~^ hs_s1, VGA_VS = VS_POL ~^ vs_s1.
//  Latency: every VGA_* output lags its counter position by exactly 2 clocks, so HS/VS/RGB stay mutually aligned.
//  hs_raw = H_VIS+H_FP <= h < H_VIS+H_FP+H_SYNC; vs_raw the same on v with V_* params.
//   vs_raw changes only on line boundaries.
//  Blanking: RGB is forced to 0 in all non-visible cycles, regardless of pix_rgb.
//  Reset (asynchronous, any time including mid-line):
//   h=0, v=0, pipeline regs cleared, VGA_R/G/B=0.
//   VGA_HS=~HS_POL, VGA_VS=~VS_POL (inactive level).
//   pix_req=0, pix_x=0, pix_y=0, frame_start=0, line_start=0 while rst_n=0.
//  Release: the first rising edge after rst_n=1 evaluates (0,0). That edge gives frame_start=1 and line_start=1.
//   The first visible RGB appears 2 clocks later.
//  Widths: compares are done at HCW/VCW width. Parameter sums are checked at elaboration: an $error fires if any region is 0.
// CONFIGURATION
//  VGA_TESTPAT_EN defined:
//   Stage-1 colour is replaced by an internal pattern; pix_rgb is ignored (framebuffer not needed).
//   Pattern: 8 vertical bars, each H_VIS/8 wide. Bar index b = pix_x*8/H_VIS.
//   R = {COLOR_W{b[2]}}, G = {COLOR_W{b[1]}}, B = {COLOR_W{b[0]}}.
//   The x coordinate is pipelined 1 stage internally so pattern timing equals framebuffer timing.
//   pix_req is still driven.
//  Not defined: no pattern logic; RGB comes from pix_rgb only.
// TESTING
//  T1 reset:
//   Hold rst_n=0 for 10 clk -> VGA_HS=0, VGA_VS=0, RGB=0, pix_req=0 (default polarity).
//   Assert rst_n mid-line -> outputs go to reset values with no clock edge.
//  T2 line timing, defaults, pix_rgb=12'hF00:
//   Release reset -> VGA_R=4'hF on cycles 2..801.
//   VGA_HS=1 on cycles 858..977; RGB=0 on cycles 802..1041.
//   line_start repeats every 1040 clk.
//  T3 frame wrap:
//   -> frame_start period exactly 692640 clk.
//   -> VGA_VS high for exactly 6*1040 cycles, starting at line 637.
//   -> pix_req count per frame = 480000.
//  T4 params: H_VIS=640, H_FP=16, H_SYNC=96, H_BP=48, V 480/10/2/33, HS_POL=VS_POL=0
//   -> line 800 clk, frame 525 lines, VGA_HS low for 96 clk.
//  T5 latency: pix_rgb = {pix_x[3:0],pix_y[3:0],4'h0} delayed 1 clk
//   -> VGA_R at output cycle n+2 equals (pix_x at n)[3:0] for all visible n.
//  T6 VGA_TESTPAT_EN:
//   -> pixels 0..99 RGB=000, 100..199 B=F, ..., 700..799 RGB=FFF.
//   -> pix_rgb toggling has no effect.

Source files
------------

// File: rtl/vga_timing_pipe.sv
// Parametrised VGA raster engine: counters, framebuffer pixel requests, 2-stage sync-aligned RGB/HS/VS.
// Optional build macro VGA_TESTPAT_EN replaces framebuffer colour with an internal 8-bar pattern.
module vga_timing_pipe #(
    parameter int unsigned H_VIS   = 800,
    parameter int unsigned H_FP    = 56,
    parameter int unsigned H_SYNC  = 120,
    parameter int unsigned H_BP    = 64,
    parameter int unsigned V_VIS   = 600,
    parameter int unsigned V_FP    = 37,
    parameter int unsigned V_SYNC  = 6,
    parameter int unsigned V_BP    = 23,
    parameter bit          HS_POL  = 1'b1,
    parameter bit          VS_POL  = 1'b1,
    parameter int unsigned COLOR_W = 4,
    localparam int unsigned H_TOT  = H_VIS + H_FP + H_SYNC + H_BP,
    localparam int unsigned V_TOT  = V_VIS + V_FP + V_SYNC + V_BP,
    localparam int unsigned HCW    = $clog2(H_TOT),
    localparam int unsigned VCW    = $clog2(V_TOT)
) (
    input  logic                   MAX10_CLK1_50,
    input  logic                   rst_n,
    output logic                   pix_req,
    output logic [HCW-1:0]         pix_x,
    output logic [VCW-1:0]         pix_y,
    input  logic [3*COLOR_W-1:0]   pix_rgb,
    output logic                   frame_start,
    output logic                   line_start,
    output logic [COLOR_W-1:0]     VGA_R,
    output logic [COLOR_W-1:0]     VGA_G,
    output logic [COLOR_W-1:0]     VGA_B,
    output logic                   VGA_HS,
    output logic                   VGA_VS
);

    if (H_VIS == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
        V_VIS == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_param_check
        $error("vga_timing_pipe: every porch/sync/visible region must be non-zero");
    end

    localparam logic [HCW-1:0] H_VIS_C  = HCW'(H_VIS);
    localparam logic [HCW-1:0] H_SB_C   = HCW'(H_VIS + H_FP);
    localparam logic [HCW-1:0] H_SE_C   = HCW'(H_VIS + H_FP + H_SYNC);
    localparam logic [HCW-1:0] H_LAST_C = HCW'(H_TOT - 1);
    localparam logic [VCW-1:0] V_VIS_C  = VCW'(V_VIS);
    localparam logic [VCW-1:0] V_SB_C   = VCW'(V_VIS + V_FP);
    localparam logic [VCW-1:0] V_SE_C   = VCW'(V_VIS + V_FP + V_SYNC);
    localparam logic [VCW-1:0] V_LAST_C = VCW'(V_TOT - 1);

    logic [HCW-1:0]       h;
    logic [VCW-1:0]       v;
    logic                 h_vis;
    logic                 v_vis;
    logic                 hs_raw;
    logic                 vs_raw;
    logic                 hs_s1;
    logic                 vs_s1;
    logic                 de_s1;
    logic [3*COLOR_W-1:0] rgb_s1;

    always_ff @(posedge MAX10_CLK1_50 or negedge rst_n) begin
        if (!rst_n) begin
            h <= '0;
            v <= '0;
        end else if (h == H_LAST_C) begin
            h <= '0;
            v <= (v == V_LAST_C) ? '0 : v + VCW'(1);
        end else begin
            h <= h + HCW'(1);
        end
    end

    // Stage 0 outputs are gated by rst_n so they read inactive while reset is held,
    // even though the counters already sit at (0,0).
    always_comb begin
        h_vis       = (h < H_VIS_C);
        v_vis       = (v < V_VIS_C);
        hs_raw      = (h >= H_SB_C) && (h < H_SE_C);
        vs_raw      = (v >= V_SB_C) && (v < V_SE_C);
        pix_req     = rst_n && h_vis && v_vis;
        pix_x       = pix_req ? h : '0;
        pix_y       = pix_req ? v : '0;
        line_start  = rst_n && (h == '0);
        frame_start = rst_n && (h == '0) && (v == '0);
    end

    always_ff @(posedge MAX10_CLK1_50 or negedge rst_n) begin
        if (!rst_n) begin
            hs_s1 <= 1'b0;
            vs_s1 <= 1'b0;
            de_s1 <= 1'b0;
        end else begin
            hs_s1 <= hs_raw;
            vs_s1 <= vs_raw;
            de_s1 <= h_vis && v_vis;
        end
    end

`ifdef VGA_TESTPAT_EN
    localparam int unsigned    XW      = HCW + 3;
    localparam logic [XW-1:0]  H_VIS_X = XW'(H_VIS);

    logic [HCW-1:0] x_s1;
    logic [XW-1:0]  bar_num;
    logic [2:0]     bar;

    // x is delayed one stage so the pattern lines up exactly like framebuffer data.
    always_ff @(posedge MAX10_CLK1_50 or negedge rst_n) begin
        if (!rst_n) begin
            x_s1 <= '0;
        end else begin
            x_s1 <= pix_x;
        end
    end

    always_comb begin
        bar_num = {x_s1, 3'b000} / H_VIS_X;
        bar     = bar_num[2:0];
        rgb_s1  = {{COLOR_W{bar[2]}}, {COLOR_W{bar[1]}}, {COLOR_W{bar[0]}}};
    end
`else
    always_comb begin
        rgb_s1 = pix_rgb;
    end
`endif

    always_ff @(posedge MAX10_CLK1_50 or negedge rst_n) begin
        if (!rst_n) begin
            VGA_R  <= '0;
            VGA_G  <= '0;
            VGA_B  <= '0;
            VGA_HS <= ~HS_POL;
            VGA_VS <= ~VS_POL;
        end else begin
            VGA_R  <= de_s1 ? rgb_s1[3*COLOR_W-1:2*COLOR_W] : '0;
            VGA_G  <= de_s1 ? rgb_s1[2*COLOR_W-1:COLOR_W]   : '0;
            VGA_B  <= de_s1 ? rgb_s1[COLOR_W-1:0]           : '0;
            VGA_HS <= HS_POL ~^ hs_s1;
            VGA_VS <= VS_POL ~^ vs_s1;
        end
    end

endmodule

// File: tb/tb_vga_timing_pipe.sv
// Self-checking bench for vga_timing_pipe using reduced raster sizes; honours VGA_TESTPAT_EN.
module tb_vga_timing_pipe;

    localparam int HV = 16, HF = 2, H_S = 3, HB = 3, HT = 24;
    localparam int VV = 8,  VF = 1, V_S = 2, VB = 2, VT = 13;
    localparam int N_CYC = 645;

    logic        clk;
    logic        rst_n;
    logic        pix_req;
    logic [4:0]  pix_x;
    logic [3:0]  pix_y;
    logic [11:0] pix_rgb;
    logic        frame_start, line_start;
    logic [3:0]  vga_r, vga_g, vga_b;
    logic        vga_hs, vga_vs;

    logic        pix_req2;
    logic [3:0]  pix_x2;
    logic [2:0]  pix_y2;
    logic [11:0] pix_rgb2;
    logic        frame_start2, line_start2;
    logic [3:0]  vga_r2, vga_g2, vga_b2;
    logic        vga_hs2, vga_vs2;

    int n_chk;
    int n_fail;

    vga_timing_pipe #(
        .H_VIS(HV), .H_FP(HF), .H_SYNC(H_S), .H_BP(HB),
        .V_VIS(VV), .V_FP(VF), .V_SYNC(V_S), .V_BP(VB),
        .HS_POL(1'b1), .VS_POL(1'b1), .COLOR_W(4)
    ) u_dut (
        .MAX10_CLK1_50(clk), .rst_n(rst_n),
        .pix_req(pix_req), .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb),
        .frame_start(frame_start), .line_start(line_start),
        .VGA_R(vga_r), .VGA_G(vga_g), .VGA_B(vga_b),
        .VGA_HS(vga_hs), .VGA_VS(vga_vs)
    );

    // Active-low sync variant: line 12 clk (hs low at h 9..10), frame 7 lines (vs low on line 5).
    vga_timing_pipe #(
        .H_VIS(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_VIS(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .COLOR_W(4)
    ) u_dut2 (
        .MAX10_CLK1_50(clk), .rst_n(rst_n),
        .pix_req(pix_req2), .pix_x(pix_x2), .pix_y(pix_y2), .pix_rgb(pix_rgb2),
        .frame_start(frame_start2), .line_start(line_start2),
        .VGA_R(vga_r2), .VGA_G(vga_g2), .VGA_B(vga_b2),
        .VGA_HS(vga_hs2), .VGA_VS(vga_vs2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
    } out_t;

    typedef struct {
        int          cyc;
        logic        hs;
        logic        vs;
        logic [11:0] rgb_fb;
        logic [11:0] rgb_pat;
    } vec_t;

    out_t q[$];
    vec_t tab[14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [11:0] fb(input logic [4:0] x, input logic [3:0] y);
        return {x[3:0], y, x[3:0] ^ y};
    endfunction

    function automatic logic [11:0] exp_col(input int h, input int v);
        logic [4:0] xv;
        logic [3:0] yv;
        int         b;
        xv = 5'(h);
        yv = 4'(v);
        b  = h * 8 / HV;
`ifdef VGA_TESTPAT_EN
        return {{4{b[2]}}, {4{b[1]}}, {4{b[0]}}};
`else
        return fb(xv, yv);
`endif
    endfunction

    initial begin
        int          h, v, ti;
        logic        req_prev;
        logic [4:0]  x_prev;
        logic [3:0]  y_prev;
        logic        vis;
        out_t        e, got;
        int          hs2_low, vs2_low, r2_nz;

        n_chk = 0; n_fail = 0;
        hs2_low = 0; vs2_low = 0; r2_nz = 0; ti = 0;

        //           cyc  hs    vs    fb       pattern
        tab[0]  = '{   2, 1'b0, 1'b0, 12'h000, 12'h000};
        tab[1]  = '{  17, 1'b0, 1'b0, 12'hF0F, 12'hFFF};
        tab[2]  = '{  18, 1'b0, 1'b0, 12'h000, 12'h000};
        tab[3]  = '{  20, 1'b1, 1'b0, 12'h000, 12'h000};
        tab[4]  = '{  22, 1'b1, 1'b0, 12'h000, 12'h000};
        tab[5]  = '{  23, 1'b0, 1'b0, 12'h000, 12'h000};
        tab[6]  = '{  29, 1'b0, 1'b0, 12'h312, 12'h00F};
        tab[7]  = '{ 217, 1'b0, 1'b0, 12'h000, 12'h000};
        tab[8]  = '{ 218, 1'b0, 1'b1, 12'h000, 12'h000};
        tab[9]  = '{ 265, 1'b0, 1'b1, 12'h000, 12'h000};
        tab[10] = '{ 266, 1'b0, 1'b0, 12'h000, 12'h000};
        tab[11] = '{ 314, 1'b0, 1'b0, 12'h000, 12'h000};
        tab[12] = '{ 328, 1'b0, 1'b0, 12'hE0E, 12'hFFF};
        tab[13] = '{ 500, 1'b1, 1'b0, 12'h000, 12'h000};

        rst_n    = 1'b0;
        pix_rgb  = 12'($urandom);
        pix_rgb2 = 12'h5A3;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("rst_hs", vga_hs, 1'b0);
        chk("rst_vs", vga_vs, 1'b0);
        chk("rst_rgb", {vga_r, vga_g, vga_b}, 12'h000);
        chk("rst_req", pix_req, 1'b0);
        chk("rst_fs", frame_start, 1'b0);
        chk("rst_ls", line_start, 1'b0);
        chk("rst_hs2", vga_hs2, 1'b1);
        chk("rst_vs2", vga_vs2, 1'b1);

        rst_n = 1'b1;
        #1;
        for (int k = 0; k < N_CYC; k++) begin
            h   = k % HT;
            v   = (k / HT) % VT;
            vis = (h < HV) && (v < VV);

            chk("pix_req", pix_req, vis);
            chk("pix_xy", {pix_x, pix_y}, vis ? {5'(h), 4'(v)} : 9'h0);
            chk("line_start", line_start, h == 0);
            chk("frame_start", frame_start, (h == 0) && (v == 0));

            e.rgb = vis ? exp_col(h, v) : 12'h000;
            e.hs  = (h >= HV + HF) && (h < HV + HF + H_S);
            e.vs  = (v >= VV + VF) && (v < VV + VF + V_S);
            q.push_back(e);
            got = {vga_r, vga_g, vga_b, vga_hs, vga_vs};
            if (q.size() == 3) begin
                e = q.pop_front();
                chk("vga_out", got, e);
            end else begin
                chk("vga_pre", got, 14'h0);
            end

            if (ti < 14 && tab[ti].cyc == k) begin
                chk("vec_hs", vga_hs, tab[ti].hs);
                chk("vec_vs", vga_vs, tab[ti].vs);
`ifdef VGA_TESTPAT_EN
                chk("vec_rgb", {vga_r, vga_g, vga_b}, tab[ti].rgb_pat);
`else
                chk("vec_rgb", {vga_r, vga_g, vga_b}, tab[ti].rgb_fb);
`endif
                ti++;
            end

            if (k >= 2 && k <= 121) begin
                hs2_low += (vga_hs2 == 1'b0) ? 1 : 0;
                vs2_low += (vga_vs2 == 1'b0) ? 1 : 0;
                r2_nz   += (vga_r2 != 4'h0) ? 1 : 0;
            end

            req_prev = pix_req;
            x_prev   = pix_x;
            y_prev   = pix_y;
            @(posedge clk);
            #1;
            pix_rgb = req_prev ? fb(x_prev, y_prev) : 12'($urandom_range(1, 4095));
            @(negedge clk);
            #1;
        end

        chk("vec_count", 32'(ti), 32'd14);
        chk("hs2_low_cnt", 32'(hs2_low), 32'd20);
        chk("vs2_low_cnt", 32'(vs2_low), 32'd12);
`ifdef VGA_TESTPAT_EN
        chk("r2_nz_cnt", 32'(r2_nz), 32'd28);
`else
        chk("r2_nz_cnt", 32'(r2_nz), 32'd56);
`endif

        // Output currently shows h=19 (hsync active); reset must clear it with no clock edge.
        chk("pre_mid_hs", vga_hs, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_hs", vga_hs, 1'b0);
        chk("mid_rst_vs", vga_vs, 1'b0);
        chk("mid_rst_rgb", {vga_r, vga_g, vga_b}, 12'h000);
        chk("mid_rst_req", pix_req, 1'b0);
        chk("mid_rst_x", pix_x, 5'd0);
        chk("mid_rst_ls", line_start, 1'b0);
        chk("mid_rst_hs2", vga_hs2, 1'b1);

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_fs", frame_start, 1'b1);
        chk("rel_ls", line_start, 1'b1);
        chk("rel_req", pix_req, 1'b1);
        chk("rel_xy", {pix_x, pix_y}, 9'h0);
        @(posedge clk);
        #1;
        chk("rel_x1", pix_x, 5'd1);
        chk("rel_fs1", frame_start, 1'b0);
        chk("rel_ls1", line_start, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
